fp32_add_sub: RTL and testbench

Single-precision (IEEE 754 binary32) floating-point adder/subtractor with registered outputs. It is the add/sub unit of the FP calculator datapath. It computes A + B or A − B in one clock and reports overflow and underflow flags. The arithmetic core is combinational and is followed by a single output register stage.

---
 rtl/fp32_add_sub.sv | 156 +++++++++++++++
 tb/tb_fp32_add_sub.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fp32_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : fp32_add_sub
// Brief    : binary32 adder/subtractor, RNE rounding, DAZ/FTZ, one output
//            register stage. Define FP_SPECIALS_EN for NaN/Inf handling.
// Revision : 1.0
// ============================================================================
module fp32_add_sub (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        checkequation,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] lz;
    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lz = 5'(26 - i);
    end
    return lz;
  endfunction

  logic              w_sa, w_sb;
  logic [7:0]        w_ea, w_eb;
  logic [22:0]       w_fa, w_fb;
  logic [30:0]       w_key_a, w_key_b;
  logic              w_swap, w_sx, w_sy, w_eff_sub;
  logic [7:0]        w_ex, w_ey, w_dexp;
  logic [22:0]       w_fx, w_fy;
  logic [23:0]       w_mx, w_my;
  logic [49:0]       w_yshift;
  logic [26:0]       w_x27, w_y27, w_norm;
  logic [27:0]       w_sum;
  logic [4:0]        w_lz;
  logic signed [9:0] w_exp_n, w_exp_f;
  logic              w_rnd;
  logic [24:0]       w_mrnd;
  logic [22:0]       w_frac;

  logic [31:0] result_d, result_q;
  logic        overflow_d, overflow_q;
  logic        underflow_d, underflow_q;
  logic        out_valid_q;

  assign w_sa = A[31];
  assign w_sb = B[31] ^ checkequation;
  assign w_ea = A[30:23];
  assign w_eb = B[30:23];
  assign w_fa = A[22:0];
  assign w_fb = B[22:0];

  // Denormal inputs compare as zero magnitude.
  assign w_key_a = {w_ea, (w_ea != 8'd0) ? w_fa : 23'd0};
  assign w_key_b = {w_eb, (w_eb != 8'd0) ? w_fb : 23'd0};

  always_comb begin
    w_swap    = (w_key_b > w_key_a);
    w_sx      = w_swap ? w_sb : w_sa;
    w_sy      = w_swap ? w_sa : w_sb;
    w_ex      = w_swap ? w_eb : w_ea;
    w_ey      = w_swap ? w_ea : w_eb;
    w_fx      = w_swap ? w_fb : w_fa;
    w_fy      = w_swap ? w_fa : w_fb;
    w_mx      = (w_ex != 8'd0) ? {1'b1, w_fx} : 24'd0;
    w_my      = (w_ey != 8'd0) ? {1'b1, w_fy} : 24'd0;
    w_dexp    = w_ex - w_ey;
    w_yshift  = {w_my, 26'd0} >> w_dexp;
    w_x27     = {w_mx, 3'b000};
    w_y27     = (w_dexp >= 8'd26) ? {26'd0, |w_my}
                                  : {w_yshift[49:24], |w_yshift[23:0]};
    w_eff_sub = w_sx ^ w_sy;
    w_sum     = w_eff_sub ? ({1'b0, w_x27} - {1'b0, w_y27})
                          : ({1'b0, w_x27} + {1'b0, w_y27});

    if (w_sum[27]) begin
      w_lz    = 5'd0;
      w_norm  = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_exp_n = $signed({2'b00, w_ex}) + 10'sd1;
    end else begin
      w_lz    = lzc27(w_sum[26:0]);
      w_norm  = w_sum[26:0] << w_lz;
      w_exp_n = $signed({2'b00, w_ex}) - $signed({5'd0, w_lz});
    end

    // Round to nearest, ties to even on guard/round/sticky.
    w_rnd   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mrnd  = {1'b0, w_norm[26:3]} + {24'd0, w_rnd};
    w_exp_f = w_mrnd[24] ? (w_exp_n + 10'sd1) : w_exp_n;
    w_frac  = w_mrnd[24] ? w_mrnd[23:1] : w_mrnd[22:0];

    result_d    = {w_sx, w_exp_f[7:0], w_frac};
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (w_sum == 28'd0) begin
      result_d = {w_sx & w_sy, 31'd0};
    end else if (w_exp_f >= 10'sd255) begin
      result_d   = {w_sx, 8'hFF, 23'd0};
      overflow_d = 1'b1;
    end else if (w_exp_f <= 10'sd0) begin
      result_d    = {w_sx, 31'd0};
      underflow_d = 1'b1;
    end

`ifdef FP_SPECIALS_EN
    if (((w_ea == 8'hFF) && (w_fa != 23'd0)) || ((w_eb == 8'hFF) && (w_fb != 23'd0))) begin
      result_d    = C_QNAN;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if ((w_ea == 8'hFF) && (w_eb == 8'hFF)) begin
      result_d    = (w_sa == w_sb) ? {w_sa, 8'hFF, 23'd0} : C_QNAN;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if ((w_ea == 8'hFF) || (w_eb == 8'hFF)) begin
      result_d    = (w_ea == 8'hFF) ? {w_sa, 8'hFF, 23'd0} : {w_sb, 8'hFF, 23'd0};
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
`else
    if (result_d == C_QNAN) begin
      result_d = C_QNAN;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        result_q    <= result_d;
        overflow_q  <= overflow_d;
        underflow_q <= underflow_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_add_sub
// Brief    : directed-vector self-checking bench for fp32_add_sub.
// Revision : 1.0
// ============================================================================
module tb_fp32_add_sub;

  logic        clk           = 1'b0;
  logic        rst_n         = 1'b0;
  logic        in_valid      = 1'b0;
  logic        checkequation = 1'b0;
  logic [31:0] A             = 32'd0;
  logic [31:0] B             = 32'd0;
  logic        out_valid;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int n_checks = 0;
  int n_errors = 0;

  fp32_add_sub dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .A             (A),
    .B             (B),
    .checkequation (checkequation),
    .out_valid     (out_valid),
    .result        (result),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [31:0] er, input logic eo, input logic eu);
    @(negedge clk);
    A = a; B = b; checkequation = op; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".result"}, result, er);
    check({tag, ".flags"}, {30'd0, overflow, underflow}, {30'd0, eo, eu});
  endtask

  initial begin
    #12;
    check("reset.result", result, 32'd0);
    check("reset.valid", {31'd0, out_valid}, 32'd0);
    check("reset.flags", {30'd0, overflow, underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_vec("half_plus_half",  32'h3F000000, 32'h3F000000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
    run_vec("half_minus_half", 32'h3F000000, 32'h3F000000, 1'b1, 32'h00000000, 1'b0, 1'b0);
    run_vec("one_minus_two",   32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0);
    run_vec("max_plus_max",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
    run_vec("negmax_sub_max",  32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 32'hFF800000, 1'b1, 1'b0);
    run_vec("min_norm_diff",   32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1);
    run_vec("tie_even",        32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
    run_vec("tie_odd_up",      32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0);
    run_vec("above_half",      32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 1'b0, 1'b0);
    run_vec("round_carry",     32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
    run_vec("far_sticky_add",  32'h3F800000, 32'h32800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
    run_vec("far_sticky_sub",  32'h3F800000, 32'h32800000, 1'b1, 32'h3F800000, 1'b0, 1'b0);
    run_vec("cancel",          32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 1'b0, 1'b0);
    run_vec("carry_add",       32'h3FC00000, 32'h40200000, 1'b0, 32'h40800000, 1'b0, 1'b0);
    run_vec("negz_plus_negz",  32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0);
    run_vec("negz_minus_posz", 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b0);
    run_vec("daz_input",       32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
`ifdef FP_SPECIALS_EN
    run_vec("inf_plus_one",    32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0);
    run_vec("inf_minus_inf",   32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0);
    run_vec("nan_input",       32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0);
`else
    run_vec("inf_plus_one",    32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b1, 1'b0);
    run_vec("inf_minus_inf",   32'h7F800000, 32'h7F800000, 1'b1, 32'h00000000, 1'b0, 1'b0);
    run_vec("nan_input",       32'h7FC00001, 32'h3F800000, 1'b0, 32'h7F800000, 1'b1, 1'b0);
`endif
    run_vec("one_plus_one",    32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);

    // Idle cycle: result and flags must hold.
    @(negedge clk);
    in_valid = 1'b0; A = 32'h7F7FFFFF; B = 32'h7F7FFFFF;
    @(posedge clk);
    #1;
    check("hold.valid", {31'd0, out_valid}, 32'd0);
    check("hold.result", result, 32'h40000000);
    check("hold.flags", {30'd0, overflow, underflow}, 32'd0);

    // Reset asserted between edges while operands stream in.
    @(negedge clk);
    A = 32'h3F800000; B = 32'h3F800000; checkequation = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("stream.result", result, 32'h40000000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.result", result, 32'd0);
    check("async_rst.valid", {31'd0, out_valid}, 32'd0);
    check("async_rst.flags", {30'd0, overflow, underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst.valid", {31'd0, out_valid}, 32'd0);
    check("post_rst.result", result, 32'd0);
    @(negedge clk);
    A = 32'h3F000000; B = 32'h3F000000; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("first_after_rst.valid", {31'd0, out_valid}, 32'd1);
    check("first_after_rst.result", result, 32'h3F800000);
    @(negedge clk);
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
